// File: rtl/mips_ex_pkg.sv
// Shared definitions for the EX stage of the 16-bit MIPS pipeline.
// Holds the ALUOp / funct encodings, the multiply/divide FSM encoding,
// the control-bit bundle and the default datapath width.
package mips_ex_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_AND   = 2'b11
  } aluop_e;

  // R-type funct codes; 8-15 are undefined and produce 0.
  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_SLT = 4'd4;
  localparam logic [3:0] FN_MUL = 4'd5;
  localparam logic [3:0] FN_DIV = 4'd6;
  localparam logic [3:0] FN_REM = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_op_e;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic mem_to_reg;
    logic reg_write;
  } ctrl_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM bus of the EX stage.
// master: the pipeline side (drives ID/EX fields, sees EX/MEM and stall).
// slave : the execute stage itself.
interface execute_stage_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] in_PC_plus_two;
  logic [DATA_W-1:0] in_Read_data_1;
  logic [DATA_W-1:0] in_Read_data_2;
  logic [DATA_W-1:0] in_immediate;
  logic              in_ALU_Src;
  logic [1:0]        in_ALUOp;
  logic              in_RegDest;
  logic [2:0]        in_rt;
  logic [2:0]        in_rd;
  logic              in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite;

  logic              ex_stall;
  logic [DATA_W-1:0] O_branch_target;
  logic              O_zero;
  logic [DATA_W-1:0] O_ALU_result;
  logic [DATA_W-1:0] O_write_data;
  logic [2:0]        O_write_reg;
  logic              O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite;

  modport master (
    output in_PC_plus_two, in_Read_data_1, in_Read_data_2, in_immediate,
           in_ALU_Src, in_ALUOp, in_RegDest, in_rt, in_rd,
           in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite,
    input  ex_stall, O_branch_target, O_zero, O_ALU_result, O_write_data,
           O_write_reg, O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite
  );

  modport slave (
    input  in_PC_plus_two, in_Read_data_1, in_Read_data_2, in_immediate,
           in_ALU_Src, in_ALUOp, in_RegDest, in_rt, in_rd,
           in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite,
    output ex_stall, O_branch_target, O_zero, O_ALU_result, O_write_data,
           O_write_reg, O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite
  );
endinterface

// File: rtl/execute_stage_mul_div_unit.sv
// Iterative unsigned multiply / divide unit, one bit per clock.
// Ports: clk, rst (sync, active-high); start_i/op_i/a_i/b_i launch an
// operation (ignored while busy); busy_o high during the MD_CYCLES
// iterations; done_o high in the cycle of the final iteration;
// result_o holds the low product, quotient or remainder until the next start.
module mul_div_unit
  import mips_ex_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MD_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  md_op_e            op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);
  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  // acc_q: product (MUL) or partial remainder (DIV/REM)
  // x_q  : shifting multiplicand (MUL) or dividend -> quotient (DIV/REM)
  // y_q  : shifting multiplier (MUL) or divisor (DIV/REM)
  md_op_e            op_q;
  logic [DATA_W-1:0] acc_q, x_q, y_q;
  logic [DATA_W-1:0] acc_d, x_d, y_d;
  logic [CW-1:0]     count_q;
  logic              busy_q;

  // Restoring division step. The trial value never exceeds 2*divisor-1 when
  // it fits, so the low DATA_W bits always hold the new remainder. A zero
  // divisor always "fits", yielding an all-ones quotient and the dividend
  // as remainder.
  logic [DATA_W:0] trial, diff;
  logic            fits;

  always_comb begin
    trial = {acc_q, x_q[DATA_W-1]};
    diff  = trial - {1'b0, y_q};
    fits  = (trial >= {1'b0, y_q});
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    if (op_q == MD_MUL) begin
      acc_d = y_q[0] ? acc_q + x_q : acc_q;
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
    end else begin
      acc_d = fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
      x_d   = {x_q[DATA_W-2:0], fits};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= MD_MUL;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (busy_q) begin
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      count_q <= count_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end else if (start_i) begin
      op_q    <= op_i;
      acc_q   <= '0;
      x_q     <= a_i;
      y_q     <= b_i;
      count_q <= '0;
      busy_q  <= 1'b1;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = busy_q && (count_q == CW'(MD_CYCLES - 1));
  assign result_o = (op_q == MD_DIV) ? x_q : acc_q;
endmodule

// File: rtl/execute_stage.sv
// EX stage of the 16-bit MIPS pipeline.
// Ports: clk, rst (sync, active-high) and the execute_stage_if slave bus
// carrying the ID/EX fields in, the EX/MEM register fields out and the
// combinational ex_stall back to PC, IF/ID and ID/EX.
// Single-cycle ALU ops land in EX/MEM at the next edge. MUL/DIV/REM run
// through mul_div_unit under an IDLE -> BUSY -> DONE FSM; EX/MEM takes
// bubbles until DONE, where the unit result is loaded with the held controls.
module execute_stage
  import mips_ex_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MD_CYCLES = DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave ex
);
  typedef struct packed {
    ctrl_t             ctrl;
    logic [2:0]        wr_reg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] br_tgt;
    logic              zero;
  } exmem_t;

  md_state_e         state_q;
  exmem_t            exmem_q;
  exmem_t            load_d;

  logic [DATA_W-1:0] op_a, op_b, sub_res, alu_res, md_res;
  logic [3:0]        funct;
  logic              md_sel, md_busy, md_done, md_start;
  md_op_e            md_op;
  ctrl_t             ctrl_in;

  assign op_a    = ex.in_Read_data_1;
  assign op_b    = ex.in_ALU_Src ? ex.in_immediate : ex.in_Read_data_2;
  assign funct   = ex.in_immediate[3:0];
  assign sub_res = op_a - op_b;
  assign ctrl_in = '{mem_read:   ex.in_MemRead,
                     mem_write:  ex.in_MemWrite,
                     branch:     ex.in_Branch,
                     mem_to_reg: ex.in_MemtoReg,
                     reg_write:  ex.in_RegWrite};

  assign md_sel = (ex.in_ALUOp == ALUOP_RTYPE) &&
                  (funct == FN_MUL || funct == FN_DIV || funct == FN_REM);

  always_comb begin
    md_op = MD_MUL;
    if (funct == FN_DIV) md_op = MD_DIV;
    if (funct == FN_REM) md_op = MD_REM;
  end

  always_comb begin
    alu_res = '0;
    case (ex.in_ALUOp)
      ALUOP_ADD: alu_res = op_a + op_b;
      ALUOP_SUB: alu_res = sub_res;
      ALUOP_AND: alu_res = op_a & op_b;
      default: begin
        case (funct)
          FN_ADD:  alu_res = op_a + op_b;
          FN_SUB:  alu_res = sub_res;
          FN_AND:  alu_res = op_a & op_b;
          FN_OR:   alu_res = op_a | op_b;
          FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // What EX/MEM takes when an instruction retires; DONE substitutes the
  // unit result for the ALU result.
  always_comb begin
    load_d        = '0;
    load_d.ctrl   = ctrl_in;
    load_d.wr_reg = ex.in_RegDest ? ex.in_rd : ex.in_rt;
    load_d.alu    = (state_q == ST_DONE) ? md_res : alu_res;
    load_d.wdata  = ex.in_Read_data_2;
    load_d.br_tgt = ex.in_PC_plus_two + {ex.in_immediate[DATA_W-2:0], 1'b0};
    load_d.zero   = (sub_res == '0);
  end

  assign md_start = !rst && (state_q == ST_IDLE) && md_sel;

  mul_div_unit #(.DATA_W(DATA_W), .MD_CYCLES(MD_CYCLES)) u_md (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .op_i     (md_op),
    .a_i      (op_a),
    .b_i      (op_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      exmem_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_sel) begin
            state_q <= ST_BUSY;
            exmem_q <= '0;
          end else begin
            exmem_q <= load_d;
          end
        end
        ST_BUSY: begin
          exmem_q <= '0;
          if (md_done) state_q <= ST_DONE;
        end
        ST_DONE: begin
          exmem_q <= load_d;
          state_q <= ST_IDLE;
        end
        default: begin
          exmem_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The unit's busy flag tracks the BUSY state exactly, so it drives the
  // BUSY part of the stall directly.
  assign ex.ex_stall = !rst && (md_start || md_busy);

  assign ex.O_branch_target = exmem_q.br_tgt;
  assign ex.O_zero          = exmem_q.zero;
  assign ex.O_ALU_result    = exmem_q.alu;
  assign ex.O_write_data    = exmem_q.wdata;
  assign ex.O_write_reg     = exmem_q.wr_reg;
  assign ex.O_MemRead       = exmem_q.ctrl.mem_read;
  assign ex.O_MemWrite      = exmem_q.ctrl.mem_write;
  assign ex.O_Branch        = exmem_q.ctrl.branch;
  assign ex.O_MemtoReg      = exmem_q.ctrl.mem_to_reg;
  assign ex.O_RegWrite      = exmem_q.ctrl.reg_write;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, single-cycle ALU ops, branch,
// MUL/DIV/REM with stall timing, reset mid-operation, back-to-back MULs.
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  execute_stage_if #(.DATA_W(16)) bus ();

  execute_stage #(.DATA_W(16), .MD_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  // ctl = {MemRead, MemWrite, Branch, MemtoReg, RegWrite}
  task automatic set_instr(input logic [15:0] pc, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] imm, input logic src, input logic [1:0] aluop,
                           input logic regdst, input logic [2:0] rt, input logic [2:0] rd,
                           input logic [4:0] ctl);
    bus.in_PC_plus_two = pc;
    bus.in_Read_data_1 = a;
    bus.in_Read_data_2 = b;
    bus.in_immediate   = imm;
    bus.in_ALU_Src     = src;
    bus.in_ALUOp       = aluop;
    bus.in_RegDest     = regdst;
    bus.in_rt          = rt;
    bus.in_rd          = rd;
    {bus.in_MemRead, bus.in_MemWrite, bus.in_Branch, bus.in_MemtoReg, bus.in_RegWrite} = ctl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Runs a multi-cycle op already on the inputs: counts stall cycles
  // (bounded), flags any non-bubble on EX/MEM while stalling, and steps
  // through the DONE edge so the result is on the outputs on return.
  task automatic md_run(output int stalls, output bit bub_bad);
    stalls  = 0;
    bub_bad = 1'b0;
    #1;
    while (bus.ex_stall && stalls < 40) begin
      stalls++;
      step();
      if (bus.O_RegWrite || bus.O_MemRead || bus.O_MemWrite || bus.O_Branch ||
          bus.O_MemtoReg || bus.O_ALU_result != 16'h0) bub_bad = 1'b1;
    end
    step();
  endtask

  function automatic logic [4:0] ctl_out();
    return {bus.O_MemRead, bus.O_MemWrite, bus.O_Branch, bus.O_MemtoReg, bus.O_RegWrite};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    set_instr(16'h1111, 16'h0005, 16'h0006, 16'h0000, 1'b0, 2'b10, 1'b1, 3'd1, 3'd2, 5'b11111);
    step();
    step();
    total++; if (bus.ex_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.ex_stall); else passed++;
    total++; if (bus.O_ALU_result !== 16'h0 || ctl_out() !== 5'b0 || bus.O_write_reg !== 3'd0 ||
                 bus.O_branch_target !== 16'h0 || bus.O_write_data !== 16'h0 || bus.O_zero !== 1'b0)
      $display("FAIL reset_outputs got alu %h ctl %b wr %0d bt %h wd %h z %b exp all 0",
               bus.O_ALU_result, ctl_out(), bus.O_write_reg, bus.O_branch_target, bus.O_write_data, bus.O_zero);
    else passed++;
    // let a real result through, then reset must clear it
    rst = 1'b0;
    step();
    total++; if (bus.O_ALU_result !== 16'h000B) $display("FAIL pre_reset_add got %h exp 000b", bus.O_ALU_result); else passed++;
    rst = 1'b1;
    step();
    total++; if (bus.O_ALU_result !== 16'h0 || ctl_out() !== 5'b0 || bus.O_write_data !== 16'h0)
      $display("FAIL reset_clear got alu %h ctl %b wd %h exp 0", bus.O_ALU_result, ctl_out(), bus.O_write_data);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    set_instr(16'h0100, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 2'b10, 1'b1, 3'd2, 3'd5, 5'b00001);
    #1;
    total++; if (bus.ex_stall !== 1'b0) $display("FAIL add_stall got %b exp 0", bus.ex_stall); else passed++;
    step();
    total++; if (bus.O_ALU_result !== 16'h8000) $display("FAIL add_result got %h exp 8000", bus.O_ALU_result); else passed++;
    total++; if (bus.O_write_reg !== 3'd5 || ctl_out() !== 5'b00001 || bus.O_write_data !== 16'h0001 ||
                 bus.O_zero !== 1'b0 || bus.O_branch_target !== 16'h0100)
      $display("FAIL add_fields got wr %0d ctl %b wd %h z %b bt %h exp 5 00001 0001 0 0100",
               bus.O_write_reg, ctl_out(), bus.O_write_data, bus.O_zero, bus.O_branch_target);
    else passed++;
  endtask

  task automatic test_beq();
    set_instr(16'h0010, 16'h1234, 16'h1234, 16'h0004, 1'b0, 2'b01, 1'b0, 3'd3, 3'd0, 5'b00100);
    step();
    total++; if (bus.O_zero !== 1'b1 || bus.O_branch_target !== 16'h0018 || bus.O_Branch !== 1'b1 || bus.O_ALU_result !== 16'h0)
      $display("FAIL beq got z %b bt %h br %b alu %h exp 1 0018 1 0000",
               bus.O_zero, bus.O_branch_target, bus.O_Branch, bus.O_ALU_result);
    else passed++;
    // negative offset wraps: 0x0002 + (0xFFFE<<1)
    set_instr(16'h0002, 16'h0001, 16'h0002, 16'hFFFE, 1'b0, 2'b01, 1'b0, 3'd3, 3'd0, 5'b00100);
    step();
    total++; if (bus.O_zero !== 1'b0 || bus.O_branch_target !== 16'hFFFE || bus.O_ALU_result !== 16'hFFFF)
      $display("FAIL beq_neg got z %b bt %h alu %h exp 0 fffe ffff", bus.O_zero, bus.O_branch_target, bus.O_ALU_result);
    else passed++;
  endtask

  task automatic test_alu_misc();
    // I-type add with negative immediate, destination rt, load controls
    set_instr(16'h0000, 16'h0005, 16'h4444, 16'hFFFE, 1'b1, 2'b00, 1'b0, 3'd6, 3'd1, 5'b10011);
    step();
    total++; if (bus.O_ALU_result !== 16'h0003 || bus.O_write_reg !== 3'd6 || ctl_out() !== 5'b10011 || bus.O_write_data !== 16'h4444)
      $display("FAIL addi got alu %h wr %0d ctl %b wd %h exp 0003 6 10011 4444",
               bus.O_ALU_result, bus.O_write_reg, ctl_out(), bus.O_write_data);
    else passed++;
    set_instr(16'h0000, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 2'b11, 1'b0, 3'd1, 3'd1, 5'b01000);
    step();
    total++; if (bus.O_ALU_result !== 16'h00F0 || ctl_out() !== 5'b01000)
      $display("FAIL and got alu %h ctl %b exp 00f0 01000", bus.O_ALU_result, ctl_out()); else passed++;
    set_instr(16'h0000, 16'h00F0, 16'h0F00, 16'h0003, 1'b0, 2'b10, 1'b1, 3'd1, 3'd4, 5'b00001);
    step();
    total++; if (bus.O_ALU_result !== 16'h0FF0) $display("FAIL or got %h exp 0ff0", bus.O_ALU_result); else passed++;
    set_instr(16'h0000, 16'hFFFF, 16'h0001, 16'h0004, 1'b0, 2'b10, 1'b1, 3'd1, 3'd4, 5'b00001);
    step();
    total++; if (bus.O_ALU_result !== 16'h0001) $display("FAIL slt got %h exp 0001", bus.O_ALU_result); else passed++;
    set_instr(16'h0000, 16'h0003, 16'h0001, 16'h0001, 1'b0, 2'b10, 1'b1, 3'd1, 3'd4, 5'b00001);
    step();
    total++; if (bus.O_ALU_result !== 16'h0002) $display("FAIL sub_funct got %h exp 0002", bus.O_ALU_result); else passed++;
    set_instr(16'h0000, 16'h1234, 16'h0001, 16'h0009, 1'b0, 2'b10, 1'b1, 3'd1, 3'd4, 5'b00001);
    #1;
    total++; if (bus.ex_stall !== 1'b0) $display("FAIL funct9_stall got %b exp 0", bus.ex_stall); else passed++;
    step();
    total++; if (bus.O_ALU_result !== 16'h0000 || ctl_out() !== 5'b00001)
      $display("FAIL funct9 got alu %h ctl %b exp 0000 00001", bus.O_ALU_result, ctl_out()); else passed++;
  endtask

  task automatic test_mul();
    int s; bit bad;
    set_instr(16'h0000, 16'h0123, 16'h0010, 16'h0005, 1'b0, 2'b10, 1'b1, 3'd1, 3'd3, 5'b00001);
    md_run(s, bad);
    total++; if (s !== 17) $display("FAIL mul_stall_cycles got %0d exp 17", s); else passed++;
    total++; if (bad !== 1'b0) $display("FAIL mul_bubble got %b exp 0", bad); else passed++;
    total++; if (bus.O_ALU_result !== 16'h1230 || bus.O_RegWrite !== 1'b1 || bus.O_write_reg !== 3'd3)
      $display("FAIL mul_result got alu %h rw %b wr %0d exp 1230 1 3", bus.O_ALU_result, bus.O_RegWrite, bus.O_write_reg);
    else passed++;
  endtask

  task automatic test_div_rem();
    int s; bit bad;
    logic [15:0] exp_v [4];
    logic [15:0] bv    [4];
    logic [15:0] fn    [4];
    exp_v = '{16'h000E, 16'h0002, 16'hFFFF, 16'h0064};
    bv    = '{16'h0007, 16'h0007, 16'h0000, 16'h0000};
    fn    = '{16'h0006, 16'h0007, 16'h0006, 16'h0007};
    for (int i = 0; i < 4; i++) begin
      set_instr(16'h0000, 16'h0064, bv[i], fn[i], 1'b0, 2'b10, 1'b1, 3'd1, 3'd2, 5'b00001);
      md_run(s, bad);
      total++; if (s !== 17 || bad !== 1'b0) $display("FAIL divrem%0d_stall got %0d bubble_err %b exp 17 0", i, s, bad); else passed++;
      total++; if (bus.O_ALU_result !== exp_v[i] || bus.O_RegWrite !== 1'b1)
        $display("FAIL divrem%0d_result got %h rw %b exp %h 1", i, bus.O_ALU_result, bus.O_RegWrite, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_mul();
    set_instr(16'h0000, 16'h0123, 16'h0010, 16'h0005, 1'b0, 2'b10, 1'b1, 3'd1, 3'd3, 5'b00001);
    for (int i = 0; i < 5; i++) step();
    total++; if (bus.ex_stall !== 1'b1) $display("FAIL midmul_busy got %b exp 1", bus.ex_stall); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.ex_stall !== 1'b0) $display("FAIL midmul_rst_stall got %b exp 0", bus.ex_stall); else passed++;
    step();
    total++; if (bus.O_ALU_result !== 16'h0 || ctl_out() !== 5'b0 || bus.O_write_reg !== 3'd0 || bus.ex_stall !== 1'b0)
      $display("FAIL midmul_rst_out got alu %h ctl %b wr %0d st %b exp 0", bus.O_ALU_result, ctl_out(), bus.O_write_reg, bus.ex_stall);
    else passed++;
    rst = 1'b0;
    set_instr(16'h0000, 16'h0002, 16'h0003, 16'h0000, 1'b0, 2'b10, 1'b1, 3'd1, 3'd7, 5'b00001);
    #1;
    total++; if (bus.ex_stall !== 1'b0) $display("FAIL post_rst_stall got %b exp 0", bus.ex_stall); else passed++;
    step();
    total++; if (bus.O_ALU_result !== 16'h0005 || bus.O_write_reg !== 3'd7)
      $display("FAIL post_rst_add got %h wr %0d exp 0005 7", bus.O_ALU_result, bus.O_write_reg); else passed++;
  endtask

  task automatic test_back_to_back();
    int s; bit bad;
    set_instr(16'h0000, 16'h0003, 16'h0004, 16'h0005, 1'b0, 2'b10, 1'b1, 3'd1, 3'd2, 5'b00001);
    md_run(s, bad);
    total++; if (s !== 17 || bad !== 1'b0) $display("FAIL b2b_first_stall got %0d bubble_err %b exp 17 0", s, bad); else passed++;
    total++; if (bus.O_ALU_result !== 16'h000C || bus.O_write_reg !== 3'd2)
      $display("FAIL b2b_first got %h wr %0d exp 000c 2", bus.O_ALU_result, bus.O_write_reg); else passed++;
    set_instr(16'h0000, 16'h0005, 16'h0006, 16'h0005, 1'b0, 2'b10, 1'b1, 3'd1, 3'd4, 5'b00001);
    md_run(s, bad);
    total++; if (s !== 17 || bad !== 1'b0) $display("FAIL b2b_second_stall got %0d bubble_err %b exp 17 0", s, bad); else passed++;
    total++; if (bus.O_ALU_result !== 16'h001E || bus.O_write_reg !== 3'd4)
      $display("FAIL b2b_second got %h wr %0d exp 001e 4", bus.O_ALU_result, bus.O_write_reg); else passed++;
    // a bubble next: no duplicated MUL result, no restart
    set_instr(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 1'b0, 3'd0, 3'd0, 5'b00000);
    #1;
    total++; if (bus.ex_stall !== 1'b0) $display("FAIL b2b_tail_stall got %b exp 0", bus.ex_stall); else passed++;
    step();
    total++; if (ctl_out() !== 5'b0 || bus.O_ALU_result !== 16'h0)
      $display("FAIL b2b_tail got ctl %b alu %h exp 00000 0000", ctl_out(), bus.O_ALU_result); else passed++;
  endtask

  initial begin
    set_instr(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 3'd0, 3'd0, 5'b0);
    @(negedge clk);
    test_reset();
    test_add();
    test_beq();
    test_alu_misc();
    test_mul();
    test_div_rem();
    test_reset_mid_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 16-bit MIPS pipeline: consumes the ID/EX register outputs and computes the ALU result, branch target and zero flag.
- Registers all results into the EX/MEM pipeline register held inside this block.
- Adds an iterative 16-cycle multiply/divide unit; stalls upstream stages while it is busy.

Parameters:
- DATA_W, 16, datapath width.
- MD_CYCLES, 16, iterations of the multiply/divide unit (equals DATA_W).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_PC_plus_two  in  16  PC+2 from ID/EX.
- in_Read_data_1  in  16  rs operand.
- in_Read_data_2  in  16  rt operand; also the store data.
- in_immediate  in  16  sign-extended immediate; bits [3:0] are funct for R-type.
- in_ALU_Src  in  1  1 = B operand is the immediate.
- in_ALUOp  in  2  00 add, 01 sub, 10 R-type (funct), 11 and.
- in_RegDest  in  1  1 = destination is rd, 0 = rt.
- in_rt  in  3  rt field.
- in_rd  in  3  rd field.
- in_MemRead, in_MemWrite, in_Branch, in_MemtoReg, in_RegWrite  in  1 each  control bits.
- ex_stall  out  1  hold PC, IF/ID and ID/EX (combinational).
- O_branch_target  out  16  registered PC+2 + (imm<<1).
- O_zero  out  1  registered (A−B)==0.
- O_ALU_result  out  16  registered result.
- O_write_data  out  16  registered in_Read_data_2.
- O_write_reg  out  3  registered destination register.
- O_MemRead, O_MemWrite, O_Branch, O_MemtoReg, O_RegWrite  out  1 each  registered control bits.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1 at a clk edge, every registered output goes to 0, the FSM goes to IDLE and the counter clears; ex_stall=0 during reset.
- Operands: A = in_Read_data_1; B = in_ALU_Src ? in_immediate : in_Read_data_2.
- Funct codes (ALUOp=10): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed, result 1/0), 5 MUL (low 16 bits, unsigned), 6 DIV (unsigned quotient), 7 REM (unsigned remainder).
  - Funct 8–15: result 0; control bits pass unchanged.
- Arithmetic: wraps modulo 2^16; no overflow trap.
- Branch target: PC+2 + (imm<<1), truncated to 16 bits.
- Single-cycle ops: the EX/MEM register loads the result and controls at the next edge. Latency is 1 cycle and ex_stall=0.
- Multi-cycle ops (MUL/DIV/REM) use FSM states IDLE → BUSY → DONE:
  - IDLE, op is MUL/DIV/REM: latch A, B and op, set count=0, go to BUSY. ex_stall=1. EX/MEM loads a bubble (all five control bits 0, data 0).
  - BUSY: one shift-add (MUL) or restoring shift-subtract (DIV/REM) step per cycle; count increments. ex_stall=1 and EX/MEM loads a bubble. At count==MD_CYCLES−1, go to DONE.
  - DONE: ex_stall=0. EX/MEM loads the unit result with the instruction's controls and write_reg. Always return to IDLE.
  - Total: ex_stall high for MD_CYCLES+1 = 17 cycles; the result is visible at the EX/MEM outputs 18 edges after the op first appears.
- Upstream obligation: ID/EX inputs stay stable while ex_stall=1. The block samples operands only in IDLE, so upstream changes during BUSY are ignored.
- DONE never re-triggers. A back-to-back MUL in the next cycle starts from IDLE normally.
- Divide by zero: quotient = 0xFFFF, remainder = dividend. Still takes the full 17 stall cycles.
- Reset mid-operation: abort and return to IDLE; partial results are discarded; outputs go to 0.
- An instruction with all controls 0 is a bubble. It never starts the multi-cycle unit unless ALUOp=10 with funct 5–7.

Decomposition:
- Package mips_ex_pkg:
  - ALUOp constants.
  - Funct codes 0–7.
  - FSM state encoding (IDLE=0, BUSY=1, DONE=2).
  - DATA_W default.
- Sub-module mul_div_unit:
  - Inputs: start, op, a, b. Outputs: busy, done, result.
  - Holds the iterative datapath and the count.
- execute_stage holds the combinational ALU, operand muxes, FSM/stall logic and the EX/MEM register.

Test Plan:
- ADD: ALUOp=10, funct=0, A=0x7FFF, B=0x0001 → next edge O_ALU_result=0x8000, O_RegWrite=1, O_write_reg=rd; ex_stall never asserted.
- BEQ: ALUOp=01, A=B=0x1234, PC+2=0x0010, imm=0x0004, Branch=1 → O_zero=1, O_branch_target=0x0018.
- MUL: A=0x0123, B=0x0010 → ex_stall high for exactly 17 cycles with bubbles on EX/MEM, then O_ALU_result=0x1230 with RegWrite=1.
- DIV and REM: DIV 0x0064/0x0007 → 0x000E; REM → 0x0002; DIV by 0x0000 → 0xFFFF; REM by zero → 0x0064.
- Reset mid-MUL: assert rst in BUSY cycle 5 → next edge all outputs 0, ex_stall=0; a new ADD 2+3 then gives 0x0005 with 1-cycle latency.
- Back-to-back MUL, MUL (3×4, then 5×6) → results 0x000C then 0x001E, each preceded by 17 stall cycles, no lost or duplicated result.
